// File: rtl/monolith_pkg.sv
// Shared types and defaults for the circulant matrix-vector multiplier streaming shell.
package monolith_pkg;

    localparam int WORD_WIDTH_DEFAULT = 31;
    localparam int MTX_SIZE_DEFAULT   = 16;

    typedef bit [WORD_WIDTH_DEFAULT-1:0] word_t;

    typedef enum logic [1:0] {
        LOAD,
        START,
        COMPUTE,
        DRAIN
    } stream_io_state_e;

endpackage

// File: rtl/circ_mvm_stream_io.sv
// Streaming shell for the circulant multiplier: loads MTX_SIZE words, pulses the multiplier
// through reset with a stable vector, then drains the captured result word by word.
module circ_mvm_stream_io
    import monolith_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
    parameter int MTX_SIZE   = MTX_SIZE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] mul_vec    [MTX_SIZE],
    output logic                  mul_reset,
    input  logic [WORD_WIDTH-1:0] mul_result [MTX_SIZE],
    input  logic                  mul_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    localparam int               IDX_W    = $clog2(MTX_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MTX_SIZE - 1);

    stream_io_state_e      state_q, state_d;
    logic [IDX_W-1:0]      in_idx_q, in_idx_d;
    logic [IDX_W-1:0]      out_idx_q, out_idx_d;
    logic                  armed_q, armed_d;
    logic [WORD_WIDTH-1:0] vbuf_q [MTX_SIZE];
    logic [WORD_WIDTH-1:0] vbuf_d [MTX_SIZE];
    logic [WORD_WIDTH-1:0] rbuf_q [MTX_SIZE];
    logic [WORD_WIDTH-1:0] rbuf_d [MTX_SIZE];

    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        armed_d   = armed_q;
        vbuf_d    = vbuf_q;
        rbuf_d    = rbuf_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    vbuf_d[in_idx_q] = in_data;
                    if (in_idx_q == LAST_IDX) begin
                        in_idx_d = '0;
                        state_d  = START;
                    end else begin
                        in_idx_d = in_idx_q + IDX_W'(1);
                    end
                end
            end
            START: begin
                armed_d = 1'b0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                // The multiplier's valid may still reflect its reset state on the first cycle.
                armed_d = 1'b1;
                if (armed_q && mul_valid) begin
                    rbuf_d  = mul_result;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        out_idx_d = '0;
                        state_d   = LOAD;
                    end else begin
                        out_idx_d = out_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            armed_q   <= 1'b0;
            for (int i = 0; i < MTX_SIZE; i++) begin
                vbuf_q[i] <= '0;
                rbuf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            armed_q   <= armed_d;
            vbuf_q    <= vbuf_d;
            rbuf_q    <= rbuf_d;
        end
    end

    assign mul_vec   = vbuf_q;
    assign in_ready  = !reset && (state_q == LOAD);
    assign mul_reset = reset || (state_q != COMPUTE);
    assign out_valid = !reset && (state_q == DRAIN);
    assign out_last  = !reset && (state_q == DRAIN) && (out_idx_q == LAST_IDX);
    assign out_data  = rbuf_q[out_idx_q];
    assign busy      = !reset && ((state_q != LOAD) || (in_idx_q != '0));

endmodule

// File: doc/circ_mvm_stream_io.md
Name: circ_mvm_stream_io

Overview:
- Streaming front/back end for the circulant matrix-vector multiplier.
- Upstream side: accepts a vector one word per beat (valid/ready) into a MTX_SIZE-word buffer.
- Once the buffer is full, presents it in parallel to the multiplier, holds the multiplier in reset for one cycle to start it, then waits for the multiplier's valid.
- Downstream side: captures the parallel result and streams it out word by word, index 0 first, with valid/ready and a last flag.

Parameters:
- WORD_WIDTH, 31, bits per field element.
- MTX_SIZE, 16, words per vector; must be at least 2.
- IDX_W, $clog2(MTX_SIZE), width of the word index counters (derived, not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  WORD_WIDTH  input vector word
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- mul_vec  out  [WORD_WIDTH-1:0] x MTX_SIZE  parallel vector to the multiplier's vec input
- mul_reset  out  1  drives the multiplier's reset input
- mul_result  in  [WORD_WIDTH-1:0] x MTX_SIZE  multiplier result
- mul_valid  in  1  multiplier result is valid
- out_data  out  WORD_WIDTH  result word
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  current out_data is result word MTX_SIZE-1
- busy  out  1  state is not LOAD, or at least one word is loaded

Behaviour:
- States: LOAD, START, COMPUTE, DRAIN. All registers are updated on the clk rising edge.
- Reset (synchronous, wins over everything):
  - State goes to LOAD; in_idx=0 and out_idx=0.
  - Vector and result buffers are cleared to 0.
  - During the reset cycle: in_ready=0, out_valid=0, out_last=0, mul_reset=1, busy=0.
- LOAD:
  - in_ready=1 and mul_reset=1.
  - A beat (in_valid and in_ready) writes vbuf[in_idx]=in_data and increments in_idx.
  - A beat with in_idx==MTX_SIZE-1 sets in_idx=0 and moves to START.
  - in_valid low holds the state, with no bubble penalty.
- START:
  - Lasts exactly 1 cycle, with in_ready=0 and mul_reset=1.
  - Moves to COMPUTE. This guarantees the multiplier sees reset with a stable, complete mul_vec.
- COMPUTE:
  - in_ready=0 and mul_reset=0.
  - mul_valid is ignored in the first COMPUTE cycle.
  - From the second COMPUTE cycle on, mul_valid=1 captures rbuf=mul_result and moves to DRAIN.
  - No timeout; the block waits indefinitely.
- DRAIN:
  - mul_reset=1, which frees the multiplier for the next vector.
  - out_valid=1, out_data=rbuf[out_idx], out_last=(out_idx==MTX_SIZE-1).
  - out_ready=1 increments out_idx. The beat with out_last sets out_idx=0 and moves to LOAD.
  - out_ready low holds out_data stable (AXI-stream style: data must not change while valid and not ready).
- mul_vec is driven continuously from vbuf. vbuf changes only in LOAD, so it is stable from START through DRAIN.
- Outputs are registered or decoded from state/counters only. There are no combinational paths from in_valid to in_ready or from out_ready to out_valid.
- Latency: last input beat, then 1 cycle START, then COMPUTE (at least 2 cycles plus the multiplier latency), then the first out_valid.
- Throughput: one vector in flight; no overlap of LOAD with DRAIN.
- Simultaneous events:
  - in_valid in any state other than LOAD is not accepted (in_ready=0); upstream must hold the word.
  - mul_valid outside COMPUTE is ignored.
- Reset mid-operation (any state) discards partial input and pending results; the first output after reset comes from a fully newly loaded vector.
- No arithmetic in this block; words pass through unmodified (reduction is the multiplier's concern).

Decomposition:
- Shared package monolith_pkg holds:
  - WORD_WIDTH_DEFAULT=31 and MTX_SIZE_DEFAULT=16.
  - typedef word_t (bit [WORD_WIDTH-1:0]).
  - typedef enum logic [1:0] stream_io_state_e {LOAD, START, COMPUTE, DRAIN}.
- The block is a single module with no sub-module.
- For integration and test, a wrapper circ_mvm_stream_top instantiates circ_mvm_stream_io plus circ_mtx_vec_mul:
  - mul_reset drives the multiplier's reset.
  - mtx_row is a top-level input.

Test Plan (MTX_SIZE=4, WORD_WIDTH=31, bench drives circ_mvm_stream_top):
- Identity row {1,0,0,0}, stream 5,6,7,8 with in_valid continuous and out_ready=1 -> outputs 5,6,7,8 in order; out_last only on 8; in_ready low from START until the beat after 8 is consumed.
- All-ones row {1,1,1,1}, stream 1,2,3,4 -> four output words, each 10.
- Backpressure: row {0,1,0,0}, vec 1,2,3,4, out_ready toggling 1,0,0,1,... -> outputs 2,3,4,1; out_data is stable while out_ready is low; no word lost or duplicated.
- Input gaps: identity row, in_valid pattern 1,0,1,0,0,1,1 carrying 9,10,11,12 -> outputs 9,10,11,12; START is entered exactly one cycle after the beat carrying 12.
- Reset mid-LOAD after 2 words (3,3), then stream 1,2,3,4 with identity row -> outputs 1,2,3,4; reset cycle shows in_ready=0, out_valid=0, busy=0.
- Reset during DRAIN after 1 word has been output -> out_valid=0 the next cycle; a following vector 7,7,7,7 with identity row yields 7,7,7,7.
